// File: rtl/bch_chien_search_pkg.sv
// GF(2^m) helpers shared by the BCH Chien search slice:
// primitive polynomials, alpha powers, constant multipliers.
package bch_chien_search_pkg;

  // Full primitive polynomial, x^m term included.
  function automatic logic [15:0] prim_poly(input int m);
    logic [15:0] p;
    case (m)
      3:       p = 16'h000B;
      4:       p = 16'h0013;
      5:       p = 16'h0025;
      6:       p = 16'h0043;
      7:       p = 16'h0089;
      8:       p = 16'h011D;
      9:       p = 16'h0211;
      10:      p = 16'h0409;
      11:      p = 16'h0805;
      12:      p = 16'h1053;
      13:      p = 16'h201B;
      14:      p = 16'h4443;
      15:      p = 16'h8003;
      default: p = 16'h0013;
    endcase
    return p;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r == 0) ? 1 : r;
  endfunction

  // Multiply by alpha (x) modulo the primitive polynomial.
  function automatic logic [15:0] xtime(
    input logic [15:0] a,
    input int          m
  );
    logic [15:0] r;
    r = a << 1;
    if (r[m]) r = r ^ prim_poly(m);
    return r;
  endfunction

  function automatic logic [15:0] alpha_pow(
    input int e,
    input int m
  );
    logic [15:0] r;
    r = 16'h0001;
    for (int i = 0; i < e; i++) r = xtime(r, m);
    return r;
  endfunction

  // x * c with c constant: column i of the matrix
  // is c*alpha^i, selected by bit i of x.
  function automatic logic [15:0] const_mul(
    input logic [15:0] x,
    input logic [15:0] c,
    input int          m
  );
    logic [15:0] r;
    logic [15:0] col;
    r   = '0;
    col = c;
    for (int i = 0; i < 16; i++) begin
      if (i < m && x[i]) r = r ^ col;
      col = xtime(col, m);
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_chien_search_term.sv
// One Chien term register: loads sigma_j*alpha^J,
// then steps by *alpha^J on each accepted beat.
module bch_chien_term
  import bch_chien_search_pkg::*;
#(
  parameter int M = 4,
  parameter int J = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         adv,
  input  logic [M-1:0] sigma_j,
  output logic [M-1:0] term
);

  localparam logic [15:0] AJ = alpha_pow(J, M);

  logic [M-1:0] ld_v;
  logic [M-1:0] adv_v;

  always_comb begin
    ld_v  = M'(const_mul(16'(sigma_j), AJ, M));
    adv_v = M'(const_mul(16'(term), AJ, M));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  term <= '0;
    else if (load) term <= ld_v;
    else if (adv)  term <= adv_v;
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien root search: evaluates sigma(alpha^(k+1)) per beat,
// streams error flags for positions N-1..0, then reports
// root count and failure.
// Ports: start/sigma/accepted from key solver; err_valid,
// err_ready, err, err_first, err_last beat stream; busy,
// done, err_count, fail status.
module bch_chien_search
  import bch_chien_search_pkg::*;
#(
  parameter  int M  = 4,
  parameter  int T  = 3,
  parameter  int N  = (1 << M) - 1,
  localparam int CW = clog2(T + 1),
  localparam int KW = clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [M*(T+1)-1:0] sigma,
  output logic             accepted,
  output logic             busy,
  output logic             err_valid,
  input  logic             err_ready,
  output logic             err,
  output logic             err_first,
  output logic             err_last,
  output logic             done,
  output logic [CW-1:0]    err_count,
  output logic             fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [CW-1:0]   deg;
  logic [CW-1:0]   deg_in;
  logic [CW-1:0]   roots;
  logic [CW-1:0]   roots_nxt;
  logic            zero0;
  logic            run;
  logic            fire;
  logic [M-1:0]    xsum;
  logic [T:0][M-1:0] terms;

  for (genvar j = 0; j <= T; j++) begin : g_term
    bch_chien_term #(
      .M (M),
      .J (j)
    ) u_term (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accepted),
      .adv     (fire),
      .sigma_j (sigma[j*M +: M]),
      .term    (terms[j])
    );
  end

  assign run       = (state == S_RUN);
  assign fire      = run && err_ready;
  assign accepted  = start && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err_valid = run;

  always_comb begin
    xsum = '0;
    for (int j = 0; j <= T; j++) xsum = xsum ^ terms[j];
  end

  // zero0 masks the all-zero polynomial, whose sum is
  // trivially zero at every position.
  assign err       = run && (xsum == '0) && !zero0;
  assign err_first = run && (k == '0);
  assign err_last  = run && (k == KW'(N - 1));

  always_comb begin
    deg_in = '0;
    for (int j = 1; j <= T; j++)
      if (sigma[j*M +: M] != '0) deg_in = CW'(j);
  end

  assign roots_nxt = (err && roots != CW'(T)) ?
                     roots + 1'b1 : roots;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      k         <= '0;
      deg       <= '0;
      zero0     <= 1'b0;
      roots     <= '0;
      err_count <= '0;
      fail      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          k     <= '0;
          deg   <= deg_in;
          zero0 <= (sigma[M-1:0] == '0);
          roots <= '0;
        end
        S_RUN: if (err_ready) begin
          k     <= k + 1'b1;
          roots <= roots_nxt;
          if (k == KW'(N - 1)) begin
            state     <= S_DONE;
            err_count <= roots_nxt;
            fail      <= zero0 || (roots_nxt != deg);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for bch_chien_search, M=4 T=3 N=15,
// primitive polynomial x^4+x+1.
module tb_bch_chien_search;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] sigma;
  logic        accepted;
  logic        busy;
  logic        err_valid;
  logic        err_ready;
  logic        err;
  logic        err_first;
  logic        err_last;
  logic        done;
  logic [1:0]  err_count;
  logic        fail;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  bch_chien_search dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sigma     (sigma),
    .accepted  (accepted),
    .busy      (busy),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .err       (err),
    .err_first (err_first),
    .err_last  (err_last),
    .done      (done),
    .err_count (err_count),
    .fail      (fail)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Accept s, stream 15 beats, check done status.
  // stall: err_ready low on odd cycles.
  // abort_at: drop reset_n at that beat and return.
  task automatic run_word(
    input logic [15:0] s,
    input logic [14:0] emask,
    input int          ecnt,
    input logic        efail,
    input bit          stall,
    input bit          hold_start,
    input int          abort_at
  );
    int k;
    int cyc;
    bit rdy;
    @(posedge clk); #1;
    start     = 1'b1;
    sigma     = s;
    err_ready = 1'b1;
    @(negedge clk);
    chk("accepted", accepted, 1);
    chk("busy_c0", busy, 0);
    k   = 0;
    cyc = 0;
    while (k < 15 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_valid", err_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        return;
      end
      start     = hold_start;
      rdy       = !stall || (cyc % 2 == 0);
      err_ready = rdy;
      @(negedge clk);
      chk("valid", err_valid, 1);
      chk("done_run", done, 0);
      if (hold_start) chk("acc_ignored", accepted, 0);
      chk($sformatf("err_b%0d", k), err, emask[k]);
      chk($sformatf("first_b%0d", k), err_first, k == 0);
      chk($sformatf("last_b%0d", k), err_last, k == 14);
      if (rdy) k++;
    end
    chk("beats", k, 15);
    @(posedge clk); #1;
    start = 1'b0;
    cyc++;
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_done", busy, 1);
    chk("valid_done", err_valid, 0);
    chk("count", err_count, ecnt);
    chk("fail", fail, efail);
    chk("latency", cyc, stall ? 31 : 16);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    sigma     = '0;
    err_ready = 1'b0;
    #12;
    chk("rst_busy0", busy, 0);
    chk("rst_valid0", err_valid, 0);
    chk("rst_err0", err, 0);
    chk("rst_first0", err_first, 0);
    chk("rst_last0", err_last, 0);
    chk("rst_done0", done, 0);
    chk("rst_cnt0", err_count, 0);
    chk("rst_fail0", fail, 0);
    chk("rst_acc0", accepted, 0);
    reset_n = 1'b1;

    // no error: sigma = 1
    run_word(16'h0001, 15'h0000, 0, 1'b0, 0, 0, 99);
    // single error at position 5 -> beat 9
    run_word(16'h0061, 15'h0200, 1, 1'b0, 0, 0, 99);
    // errors at positions 14 and 0 -> beats 0, 14
    run_word(16'h0981, 15'h4001, 2, 1'b0, 0, 0, 99);
    // single error with alternating backpressure
    run_word(16'h0061, 15'h0200, 1, 1'b0, 1, 0, 99);
    // all-zero polynomial
    run_word(16'h0000, 15'h0000, 0, 1'b1, 0, 0, 99);
    // reset mid-word at beat 6
    run_word(16'h0061, 15'h0200, 1, 1'b0, 0, 0, 6);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_done2", done, 0);
    // restart, start held during RUN must be ignored
    run_word(16'h0981, 15'h4001, 2, 1'b0, 0, 1, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
- Error-locator root search stage. Sits directly downstream of the inversionless BMA key solver.
- Takes the locator polynomial sigma(x) of degree ≤ T, GF(2^M) coefficients in standard basis, and evaluates it at successive powers of alpha, one codeword position per cycle.
- Emits a serial error-flag stream, MSB-first (position N-1 down to 0), for the downstream correction XOR.
- At end of word, reports the number of roots found and a decode-failure flag.

Parameters:
- M, 4, GF(2^M) symbol width; the primitive polynomial comes from the shared bch.vh table.
- T, 3, correctable errors; sigma has T+1 coefficients.
- N, 2^M-1, codeword length in bits (shortened codes: N < 2^M-1).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  sigma valid from key solver; level, sampled only while idle.
- sigma  in  M*(T+1)  locator coefficients; coefficient j at [j*M+:M].
- accepted  out  1  combinational; start && idle; tells key solver sigma was taken.
- busy  out  1  high from acceptance until the done cycle inclusive.
- err_valid  out  1  error-flag beat valid.
- err_ready  in  1  downstream accepts beat.
- err  out  1  1 = bit at current position is in error.
- err_first  out  1  qualifies beat for position N-1.
- err_last  out  1  qualifies beat for position 0.
- done  out  1  one-cycle pulse after last beat is accepted.
- err_count  out  clog2(T+1)  roots found; valid from done until next acceptance.
- fail  out  1  decode failure; same validity as err_count.

Behaviour:
- Reset (async, reset_n=0): state IDLE. Outputs busy, err_valid, err, err_first, err_last, done, err_count, fail all 0. Term registers cleared. Reset mid-word aborts with no done pulse.
- States: IDLE -> RUN on acceptance; RUN -> DONE when the last beat is accepted; DONE -> IDLE unconditionally next cycle.
- Acceptance, cycle 0 (start && IDLE):
  - load term register j <= sigma_j * alpha^j for j=0..T. Term 0 is sigma_0 unmultiplied.
  - position counter <= 0.
  - deg <= index of highest nonzero coefficient.
  - zero0 <= (sigma_0 == 0).
  - root counter <= 0.
- RUN:
  - beat k (k = 0..N-1) is for position N-1-k and evaluates sigma(alpha^(k+1)) = sigma(alpha^-(N-1-k)).
  - err = (XOR of all term registers == 0) && !zero0. This is combinational from the registers.
  - err_valid=1 throughout RUN; the first beat appears in cycle 1.
  - On err_valid && err_ready:
    - term j <= term j * alpha^j (constant multiplier);
    - k <= k+1;
    - root counter += err.
  - On err_valid && !err_ready, all state holds and err, err_first, err_last stay stable.
  - err_first = (k==0); err_last = (k==N-1).
- Throughput: N beats in N cycles with err_ready held high. done is asserted in cycle N+1 after acceptance.
- DONE cycle: done=1; err_count <= root counter; fail <= zero0 || (root counter != deg).
- Root counter saturates at T. It cannot exceed deg when sigma_0 ≠ 0.
- start while busy is ignored and accepted stays 0. Back-to-back operation: a start present in the DONE cycle is accepted in the following IDLE cycle.
- sigma = 0 polynomial: zero0=1, all err beats are 0, fail=1, err_count=0.

Decomposition:
- bch.vh (shared):
  - primitive polynomial per M;
  - log2/clog2 functions;
  - a function returning alpha^e in standard basis;
  - a constant-multiplier matrix generator.
  No new package-level typedefs.
- Sub-module: bch_chien_term #(M, J). Holds one term register, with a load mux (sigma_j*alpha^J) and a hold/advance enable (×alpha^J). It is instantiated T+1 times by array instantiation.
- Control FSM, counters and the XOR-reduce live in the top module.

Test Plan (M=4, T=3, N=15, x^4+x+1, coefficients listed j=0..3):
- No-error, sigma={0001,0,0,0}, err_ready=1 -> accepted pulses in cycle 0; 15 beats all err=0; err_first on beat 0, err_last on beat 14; done in cycle 16; err_count=0, fail=0.
- Single error, sigma={0001,0110(alpha^5),0,0} -> err=1 only on beat 9 (position 5); err_count=1, fail=0.
- Two errors at positions 14 and 0, sigma={0001,1000,1001,0} -> err=1 on beats 0 and 14 only; err_count=2, fail=0.
- Backpressure: single-error case with err_ready low on alternating cycles -> identical beat sequence, err and flags stable while stalled, done after the 15th handshake.
- sigma all zero -> all err=0, err_count=0, fail=1.
- Reset mid-word: drop reset_n at beat 6 -> same cycle err_valid=0, busy=0, no done. After release, a new start is accepted and completes normally. Also check start held during RUN is ignored (accepted=0).
